// File: rtl/mult_div_sequencer_if.sv
// Control-unit <-> multiply/divide sequencer handshake bundle.
// The control unit owns the master side; the sequencer owns the slave side.
interface mult_div_sequencer_if;
    logic start;
    logic op;
    logic div_by_zero;
    logic flush;
    logic mult_op;
    logic div_op;
    logic mult_div_sel;
    logic hilo_write;
    logic busy;
    logic done;
    logic div_zero_exc;

    modport master (
        output start, op, div_by_zero, flush,
        input  mult_op, div_op, mult_div_sel, hilo_write, busy, done, div_zero_exc
    );

    modport slave (
        input  start, op, div_by_zero, flush,
        output mult_op, div_op, mult_div_sel, hilo_write, busy, done, div_zero_exc
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Sequences the shared mult/div units: start pulse, fixed-latency wait,
// HI/LO write and done, or a divide-by-zero exception.
module mult_div_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input logic                  clk,
    input logic                  reset,
    mult_div_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        COUNT = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        EXC   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_q;
    logic             mult_op_q;
    logic             div_op_q;
    logic             hilo_write_q;
    logic             done_q;
    logic             exc_q;
    logic             busy_q;

    // Pulse registers are loaded on the transition into their state, so each
    // output is high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= 1'b0;
            mult_op_q    <= 1'b0;
            div_op_q     <= 1'b0;
            hilo_write_q <= 1'b0;
            done_q       <= 1'b0;
            exc_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            mult_op_q    <= 1'b0;
            div_op_q     <= 1'b0;
            hilo_write_q <= 1'b0;
            done_q       <= 1'b0;
            exc_q        <= 1'b0;
            if (bus.flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            op_q      <= bus.op;
                            mult_op_q <= ~bus.op;
                            div_op_q  <= bus.op;
                            busy_q    <= 1'b1;
                            state_q   <= START;
                        end
                    end
                    START: begin
                        if (op_q && bus.div_by_zero) begin
                            exc_q   <= 1'b1;
                            state_q <= EXC;
                        end else begin
                            cnt_q   <= op_q ? DIV_LOAD : MULT_LOAD;
                            state_q <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (cnt_q == '0) begin
                            hilo_write_q <= 1'b1;
                            state_q      <= WRITE;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    WRITE: begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    EXC: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // flush kills any pulse in the same cycle it is raised.
    assign bus.mult_op      = mult_op_q    & ~bus.flush;
    assign bus.div_op       = div_op_q     & ~bus.flush;
    assign bus.hilo_write   = hilo_write_q & ~bus.flush;
    assign bus.done         = done_q       & ~bus.flush;
    assign bus.div_zero_exc = exc_q        & ~bus.flush;
    assign bus.busy         = busy_q;
    assign bus.mult_div_sel = op_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Bench for mult_div_sequencer: two instances (default latencies and 1/3)
// share one stimulus stream and are checked against a timeline model.
module tb_mult_div_sequencer;

    logic clk;
    logic reset;
    logic start_s;
    logic op_s;
    logic dbz_s;
    logic flush_s;

    int errors = 0;
    int checks = 0;

    mult_div_sequencer_if if_a ();
    mult_div_sequencer_if if_b ();

    assign if_a.start       = start_s;
    assign if_a.op          = op_s;
    assign if_a.div_by_zero = dbz_s;
    assign if_a.flush       = flush_s;
    assign if_b.start       = start_s;
    assign if_b.op          = op_s;
    assign if_b.div_by_zero = dbz_s;
    assign if_b.flush       = flush_s;

    mult_div_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(6)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    mult_div_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(3), .CNT_W(6)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs: {mult_op, div_op, mult_div_sel, hilo_write, busy, done, div_zero_exc}
    logic [6:0] obs [2];
    assign obs[0] = {if_a.mult_op, if_a.div_op, if_a.mult_div_sel, if_a.hilo_write,
                     if_a.busy, if_a.done, if_a.div_zero_exc};
    assign obs[1] = {if_b.mult_op, if_b.div_op, if_b.mult_div_sel, if_b.hilo_write,
                     if_b.busy, if_b.done, if_b.div_zero_exc};

    string sig_name [7] = '{"div_zero_exc", "done", "busy", "hilo_write",
                            "mult_div_sel", "div_op", "mult_op"};

    // Reference: a command accepted at edge 0 is at timeline position t=1 in
    // cycle 1; pulses fall at fixed positions of that timeline.
    int  n_mult [2] = '{32, 1};
    int  n_div  [2] = '{32, 3};
    bit  m_act  [2];
    int  m_t    [2];
    bit  m_op   [2];
    bit  m_exc  [2];
    bit  m_sel  [2];
    int  cyc;

    function automatic logic [6:0] expected(int k, bit f);
        int  n;
        bit  mo, dv, hw, bs, dn, ex;
        n  = m_op[k] ? n_div[k] : n_mult[k];
        bs = m_act[k];
        mo = m_act[k] && m_t[k] == 1 && !m_op[k] && !f;
        dv = m_act[k] && m_t[k] == 1 &&  m_op[k] && !f;
        hw = m_act[k] && !m_exc[k] && m_t[k] == n + 2 && !f;
        dn = m_act[k] && !m_exc[k] && m_t[k] == n + 3 && !f;
        ex = m_act[k] &&  m_exc[k] && m_t[k] == 2 && !f;
        return {mo, dv, m_sel[k], hw, bs, dn, ex};
    endfunction

    task automatic model_step(int k);
        int n;
        n = m_op[k] ? n_div[k] : n_mult[k];
        if (flush_s) begin
            m_act[k] = 1'b0;
        end else if (m_act[k]) begin
            if (m_t[k] == 1 && m_op[k] && dbz_s) m_exc[k] = 1'b1;
            m_t[k]++;
            if (m_exc[k] ? (m_t[k] > 2) : (m_t[k] > n + 3)) m_act[k] = 1'b0;
        end else if (start_s) begin
            m_act[k] = 1'b1;
            m_t[k]   = 1;
            m_op[k]  = op_s;
            m_sel[k] = op_s;
            m_exc[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0;
            m_t[k]   = 0;
            m_op[k]  = 1'b0;
            m_exc[k] = 1'b0;
            m_sel[k] = 1'b0;
        end
    endtask

    task automatic check_bit(string tag, int k, logic got, logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d cycle=%0d observed=%b expected=%b", tag, k, cyc, got, exp);
        end
    endtask

    task automatic check_all(int k, logic [6:0] exp);
        for (int b = 0; b < 7; b++) check_bit(sig_name[b], k, obs[k][b], exp[b]);
    endtask

    // One clock cycle: drive at negedge, check just after, advance model at posedge.
    task automatic cycle(input logic s, input logic o, input logic z, input logic f);
        @(negedge clk);
        start_s = s;
        op_s    = o;
        dbz_s   = z;
        flush_s = f;
        #1;
        for (int k = 0; k < 2; k++) check_all(k, expected(k, f));
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int starts_seen;

    initial begin
        cyc     = 0;
        reset   = 1'b0;
        start_s = 1'b0;
        op_s    = 1'b0;
        dbz_s   = 1'b0;
        flush_s = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_all(k, 7'b0);
        @(negedge clk);
        reset = 1'b1;

        // MULT, then DIV, then DIV with divisor zero
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(38);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycles(38);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(38);
        // MULT with div_by_zero high is unaffected
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(38);

        // MULT flushed in cycle 10, then start+flush in IDLE
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(8);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(3);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        idle_cycles(3);

        // second start during COUNT is ignored
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(5);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycles(38);

        // back-to-back starts every cycle
        for (int i = 0; i < 80; i++) cycle(1'b1, i[2], 1'b0, 1'b0);

        // asynchronous reset in the middle of COUNT
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(4);
        #3;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check_all(k, 7'b0);
        start_s = 1'b0;
        flush_s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle_cycles(6);

        // randomized traffic
        starts_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            logic s, o, z, f;
            s = ($urandom_range(0, 3) == 0);
            o = $urandom_range(0, 1);
            z = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 39) == 0);
            if (s) starts_seen++;
            cycle(s, o, z, f);
        end
        idle_cycles(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
